// File: rtl/alu_mc_pkg.sv
// ============================================================================
// Module : alu_mc_pkg
// Brief  : Opcode encodings and FSM state type shared by the multi-cycle ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_mc_pkg;

  // Opcode map (4-bit sel field); 4'hC..4'hF are invalid unless DIV is built in
  localparam logic [3:0] OP_ADD          = 4'h0;
  localparam logic [3:0] OP_SUB          = 4'h1;
  localparam logic [3:0] OP_AND          = 4'h2;
  localparam logic [3:0] OP_OR           = 4'h3;
  localparam logic [3:0] OP_XOR          = 4'h4;
  localparam logic [3:0] OP_NOR          = 4'h5;
  localparam logic [3:0] OP_NAND         = 4'h6;
  localparam logic [3:0] OP_XNOR         = 4'h7;
  localparam logic [3:0] OP_EQU          = 4'h8;
  localparam logic [3:0] OP_GREATER_THAN = 4'h9;
  localparam logic [3:0] OP_LESS_THAN    = 4'hA;
  localparam logic [3:0] OP_MODULO       = 4'hB;
  localparam logic [3:0] OP_DIV          = 4'hC;

  // Controller states: accept/single-cycle vs. serial divide iteration
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mc_if.sv
// ============================================================================
// Module : alu_mc_if
// Brief  : Operand-in / result-out valid-ready bundle for alu_mc.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             error;
  logic             zero;
  logic             carry;
  logic             overflow;

  // Issue side drives operands and accepts results
  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, out, error, zero, carry, overflow
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, out, error, zero, carry, overflow
  );

endinterface

`default_nettype wire

// File: rtl/alu_divider.sv
// ============================================================================
// Module : alu_divider
// Brief  : Serial restoring divider, one quotient bit per clock. done_o is
//          asserted during the final iteration cycle; quotient_o/remainder_o
//          present the values that iteration produces, so the owner can
//          capture them on the same edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_divider #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start_i,
  input  wire logic [WIDTH-1:0] dividend_i,
  input  wire logic [WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      quotient_o,
  output logic [WIDTH-1:0]      remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The partial remainder stays below the divisor, so bit WIDTH of the
  // difference is a clean borrow indicator.
  always_comb begin
    w_shift = {rem_q, quo_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, dvs_q};
    if (!w_diff[WIDTH]) begin
      rem_d = w_diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = w_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Load operands on start, then iterate until the counter drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      cnt_q <= CW'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (busy_o) begin
      cnt_q <= cnt_q - CW'(1);
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign done_o      = (cnt_q == CW'(1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module : alu_mc
// Brief  : Registered multi-cycle ALU with valid/ready handshakes. Logic,
//          arithmetic and compare ops complete in one cycle; MODULO (and DIV
//          when the ALU_DIV_EN macro is defined) runs on alu_divider.
// Config : ALU_DIV_EN - enables opcode 4'hC as unsigned divide (quotient).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire logic clk,
  input wire logic rst,
  alu_mc_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic             err_q, zero_q, carry_q, ovf_q, out_valid_q;
  logic             op_div_q;

  logic             w_in_ready, w_accept, w_is_divop, w_start;
  logic             w_div_busy, w_div_done;
  logic [WIDTH-1:0] w_quo, w_rem, w_div_res;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] res_d;
  logic             err_d, carry_d, ovf_d;

`ifdef ALU_DIV_EN
  assign w_is_divop = (bus.sel == OP_MODULO) || (bus.sel == OP_DIV);
`else
  assign w_is_divop = (bus.sel == OP_MODULO);
`endif

  assign w_in_ready = !rst && (state_q == S_IDLE) && !w_div_busy &&
                      (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  // Divide by zero never reaches the divider; it resolves as a 1-cycle error
  assign w_start    = w_accept && w_is_divop && (bus.b != '0);
  // op_div_q can only be set when the DIV opcode is decoded as a divider op
  assign w_div_res  = op_div_q ? w_quo : w_rem;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_start),
    .dividend_i (bus.a),
    .divisor_i  (bus.b),
    .busy_o     (w_div_busy),
    .done_o     (w_div_done),
    .quotient_o (w_quo),
    .remainder_o(w_rem)
  );

  // Single-cycle datapath; anything not listed (MODULO/DIV by zero, invalid) errors with out=0
  always_comb begin
    w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    res_d   = '0;
    err_d   = 1'b0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        {carry_d, res_d} = w_sum;
        ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res_d[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = bus.a - bus.b;
        carry_d = (bus.a < bus.b);
        ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res_d[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:          res_d = bus.a & bus.b;
      OP_OR:           res_d = bus.a | bus.b;
      OP_XOR:          res_d = bus.a ^ bus.b;
      OP_NOR:          res_d = ~(bus.a | bus.b);
      OP_NAND:         res_d = ~(bus.a & bus.b);
      OP_XNOR:         res_d = ~(bus.a ^ bus.b);
      OP_EQU:          res_d = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      OP_GREATER_THAN: res_d = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
      OP_LESS_THAN:    res_d = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      default:         err_d = 1'b1;
    endcase
  end

  // Controller and result slot; a new result load takes priority over a drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      err_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      op_div_q    <= 1'b0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start) begin
              state_q  <= S_DIV;
              op_div_q <= (bus.sel == OP_DIV);
            end else begin
              out_q       <= res_d;
              err_q       <= err_d;
              zero_q      <= (res_d == '0);
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            out_q       <= w_div_res;
            err_q       <= 1'b0;
            zero_q      <= (w_div_res == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.error     = err_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module : tb_alu_mc
// Brief  : Directed + randomized self-checking bench for alu_mc (WIDTH=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;
  typedef logic [W+3:0] res_t;  // {out, error, zero, carry, overflow}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 2**(W-1)) ? x - 2**W : x;
  endfunction

  // Reference model straight from the opcode definitions, in integer arithmetic
  function automatic res_t model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, r, t;
    bit e, c, o;
    logic [W-1:0] v;
    ua = int'(a); ub = int'(b); r = 0; e = 0; c = 0; o = 0;
    case (s)
      OP_ADD: begin
        r = ua + ub; c = (r >= 2**W); r = r % (2**W);
        t = sgn(ua) + sgn(ub); o = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      OP_SUB: begin
        r = ua - ub; c = (ua < ub); if (r < 0) r = r + 2**W;
        t = sgn(ua) - sgn(ub); o = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      OP_NOR:  begin v = ~(a | b); r = int'(v); end
      OP_NAND: begin v = ~(a & b); r = int'(v); end
      OP_XNOR: begin v = ~(a ^ b); r = int'(v); end
      OP_EQU:  r = (ua == ub) ? 1 : 0;
      OP_GREATER_THAN: r = (ua > ub) ? 1 : 0;
      OP_LESS_THAN:    r = (ua < ub) ? 1 : 0;
      OP_MODULO: if (ub == 0) e = 1; else r = ua % ub;
`ifdef ALU_DIV_EN
      OP_DIV:    if (ub == 0) e = 1; else r = ua / ub;
`endif
      default: e = 1;
    endcase
    return {W'(r), e, (r == 0), c, o};
  endfunction

  function automatic res_t obs();
    return {bus.out, bus.error, bus.zero, bus.carry, bus.overflow};
  endfunction

  // Present a beat and hold it until accepted; returns #1 after the accept edge
  task automatic send(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    bus.in_valid = 1'b1; bus.sel = s; bus.a = a; bus.b = b; ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Stall the consumer for a while, then take one result and compare it
  task automatic collect(input string tag, input res_t exp_v, input int stall);
    bit got;
    bus.out_ready = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        check(tag, obs(), exp_v);
      end
      @(posedge clk); #1;
    end
    check({tag, "_arrive"}, got, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ok;
    int           k, lowready, seen;
    logic [3:0]   s;
    logic [W-1:0] ra, rb;
    res_t         r1;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_outputs", obs(), 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0; #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Reset in the middle of a MODULO
    send(OP_MODULO, 8'd200, 8'd7, ok);
    check("mid_accept", ok, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_outputs", obs(), 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1; rst = 1'b0; #1;
    check("mid_release_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    check("no_stale_result", seen, 0);

    // Arithmetic corner cases
    send(OP_ADD, 8'hF0, 8'h20, ok);
    check("add_lat1", bus.out_valid, 1);
    collect("add_carry", {8'h10, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
    send(OP_ADD, 8'h7F, 8'h01, ok);
    collect("add_ovf", {8'h80, 1'b0, 1'b0, 1'b0, 1'b1}, 0);
    send(OP_SUB, 8'h80, 8'h01, ok);
    collect("sub_ovf", {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}, 0);
    send(OP_SUB, 8'h03, 8'h05, ok);
    collect("sub_borrow", {8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}, 1);

    // MODULO latency and in_ready gating
    bus.out_ready = 1'b1;
    send(OP_MODULO, 8'd200, 8'd7, ok);
    check("mod_accept", ok, 1);
    k = 0; lowready = 0;
    while (!bus.out_valid && k < 20) begin
      if (!bus.in_ready) lowready++;
      @(posedge clk); #1; k++;
    end
    check("mod_latency", k, 8);
    check("mod_in_ready_low", lowready, 8);
    check("mod_result", obs(), {8'd4, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    send(OP_MODULO, 8'd55, 8'd0, ok);
    check("mod0_lat1", bus.out_valid, 1);
    check("mod0_result", obs(), {8'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Backpressure: result held, second beat waits, nothing lost or doubled
    bus.out_ready = 1'b0;
    send(OP_XOR, 8'h5A, 8'h0F, ok);
    r1 = model(OP_XOR, 8'h5A, 8'h0F);
    bus.in_valid = 1'b1; bus.sel = OP_XOR; bus.a = 8'hA5; bus.b = 8'hFF;
    repeat (3) begin
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_hold", {bus.out_valid, obs()}, {1'b1, r1});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1; #1;
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("release_beat2", {bus.out_valid, obs()}, {1'b1, model(OP_XOR, 8'hA5, 8'hFF)});
    @(posedge clk); #1;
    check("no_duplicate", bus.out_valid, 0);

    // Streaming single-cycle ops: one result per cycle
    for (int i = 0; i < 10; i++) begin
      s = 4'($urandom_range(0, 10)); ra = W'($urandom); rb = W'($urandom);
      bus.in_valid = 1'b1; bus.sel = s; bus.a = ra; bus.b = rb;
      check("stream_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      check("stream_result", {bus.out_valid, obs()}, {1'b1, model(s, ra, rb)});
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Invalid and optional opcodes
    send(4'hF, 8'h12, 8'h34, ok);
    collect("sel_F", {8'd0, 1'b1, 1'b1, 1'b0, 1'b0}, 0);
    send(4'hC, 8'd200, 8'd7, ok);
`ifdef ALU_DIV_EN
    collect("sel_C_div", {8'd28, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
`else
    check("sel_C_lat1", bus.out_valid, 1);
    collect("sel_C_invalid", {8'd0, 1'b1, 1'b1, 1'b0, 1'b0}, 0);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      s  = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(s, ra, rb, ok);
      check("rand_accept", ok, 1);
      collect("rand_result", model(s, ra, rb), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
